// File: rtl/datapath_pkg.sv
// Shared definitions for the sequenced datapath.
// Contents: op-kind, ALU-op and shift codes; FSM state encoding; flag bit
// positions inside the {N, V, Z} status vector.
package datapath_pkg;

  localparam logic [1:0] OPK_ALU  = 2'd0;
  localparam logic [1:0] OPK_MOVI = 2'd1;
  localparam logic [1:0] OPK_CMP  = 2'd2;
  localparam logic [1:0] OPK_RSVD = 2'd3;

  localparam logic [1:0] ALUOP_ADD  = 2'd0;
  localparam logic [1:0] ALUOP_SUB  = 2'd1;
  localparam logic [1:0] ALUOP_AND  = 2'd2;
  localparam logic [1:0] ALUOP_NOTB = 2'd3;

  localparam logic [1:0] SHIFT_NONE = 2'd0;
  localparam logic [1:0] SHIFT_LSL1 = 2'd1;
  localparam logic [1:0] SHIFT_LSR1 = 2'd2;
  localparam logic [1:0] SHIFT_ASR1 = 2'd3;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDA  = 3'd1,
    ST_RDB  = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_e;

endpackage

// File: rtl/datapath_seq_regfile.sv
// Parametrised register file: one synchronous write port, one
// combinational read port. Contents are deliberately not reset.
// Ports: clk; we/waddr/wdata write port; raddr -> rdata read port.
module regfile_param
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [RW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [RW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [NREGS];

  // Register storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/datapath_seq.sv
// Self-sequenced datapath: register file, A/B operand registers, shifter,
// ALU, result register C and {N, V, Z} flags. One op is accepted through a
// valid/ready handshake and stepped through RDA/RDB/EXEC/WB internally.
// Ports: clk, reset (sync, active-high); op_* request with op_ready;
// ext_* host register load (IDLE only); result (C), flags {N,V,Z}, done.
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int IMM_W = 5,
  localparam int RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_kind,
  input  logic [RW-1:0]    op_rn,
  input  logic [RW-1:0]    op_rm,
  input  logic [RW-1:0]    op_rd,
  input  logic [1:0]       op_aluop,
  input  logic [1:0]       op_shift,
  input  logic             op_asel,
  input  logic             op_bsel,
  input  logic [IMM_W-1:0] op_imm,
  input  logic             ext_write,
  input  logic [RW-1:0]    ext_num,
  input  logic [WIDTH-1:0] ext_data,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0]       flags_q, flags_d;
  logic             done_q, done_d, ready_q, ready_d;
  logic [1:0]       kind_q, kind_d, aluop_q, aluop_d, shift_q, shift_d;
  logic [RW-1:0]    rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
  logic             asel_q, asel_d, bsel_q, bsel_d;
  logic [IMM_W-1:0] imm_q, imm_d;

  logic             rf_we_s;
  logic [RW-1:0]    rf_waddr_s, rf_raddr_s;
  logic [WIDTH-1:0] rf_wdata_s, rf_rdata_s;
  logic [WIDTH-1:0] opa_s, opb_s;
  logic [WIDTH:0]   alu_s;

  function automatic logic [WIDTH-1:0] shift_b(input logic [WIDTH-1:0] b,
                                               input logic [1:0] mode);
    logic [WIDTH-1:0] r;
    case (mode)
      SHIFT_NONE: r = b;
      SHIFT_LSL1: r = {b[WIDTH-2:0], 1'b0};
      SHIFT_LSR1: r = {1'b0, b[WIDTH-1:1]};
      SHIFT_ASR1: r = {b[WIDTH-1], b[WIDTH-1:1]};
      default:    r = b;
    endcase
    return r;
  endfunction

  // Returns {V, result}; V only meaningful for ADD/SUB.
  function automatic logic [WIDTH:0] alu_f(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [1:0] op);
    logic [WIDTH-1:0] r;
    logic v;
    case (op)
      ALUOP_ADD: begin
        r = a + b;
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      ALUOP_SUB: begin
        r = a - b;
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      ALUOP_AND: begin
        r = a & b;
        v = 1'b0;
      end
      ALUOP_NOTB: begin
        r = ~b;
        v = 1'b0;
      end
      default: begin
        r = {WIDTH{1'b0}};
        v = 1'b0;
      end
    endcase
    return {v, r};
  endfunction

  // Operand selection and ALU evaluation from the A/B registers
  always_comb begin
    if (asel_q) begin
      opa_s = {WIDTH{1'b0}};
    end else begin
      opa_s = a_q;
    end
    if (bsel_q) begin
      opb_s = {{(WIDTH-IMM_W){1'b0}}, imm_q};
    end else begin
      opb_s = shift_b(b_q, shift_q);
    end
    alu_s = alu_f(opa_s, opb_s, aluop_q);
  end

  // Next-state, datapath-register and register-file port control
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    flags_d = flags_q;
    done_d = 1'b0;
    kind_d = kind_q;
    aluop_d = aluop_q;
    shift_d = shift_q;
    rn_d = rn_q;
    rm_d = rm_q;
    rd_d = rd_q;
    asel_d = asel_q;
    bsel_d = bsel_q;
    imm_d = imm_q;
    rf_we_s = 1'b0;
    rf_waddr_s = rd_q;
    rf_wdata_s = c_q;
    // The single read port serves rn during RDA and rm during RDB.
    if (state_q == ST_RDB) begin
      rf_raddr_s = rm_q;
    end else begin
      rf_raddr_s = rn_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (ext_write) begin
          rf_we_s = 1'b1;
          rf_waddr_s = ext_num;
          rf_wdata_s = ext_data;
        end else begin
          rf_we_s = 1'b0;
        end
        if (op_valid) begin
          kind_d = op_kind;
          aluop_d = op_aluop;
          shift_d = op_shift;
          rn_d = op_rn;
          rm_d = op_rm;
          rd_d = op_rd;
          asel_d = op_asel;
          bsel_d = op_bsel;
          imm_d = op_imm;
          case (op_kind)
            OPK_ALU, OPK_CMP: state_d = ST_RDA;
            OPK_MOVI: begin
              c_d = {{(WIDTH-IMM_W){op_imm[IMM_W-1]}}, op_imm};
              state_d = ST_WB;
            end
            default: done_d = 1'b1;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RDA: begin
        a_d = rf_rdata_s;
        state_d = ST_RDB;
      end
      ST_RDB: begin
        b_d = rf_rdata_s;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        flags_d[FLAG_Z] = (alu_s[WIDTH-1:0] == {WIDTH{1'b0}});
        flags_d[FLAG_N] = alu_s[WIDTH-1];
        flags_d[FLAG_V] = alu_s[WIDTH];
        if (kind_q == OPK_ALU) begin
          c_d = alu_s[WIDTH-1:0];
          state_d = ST_WB;
        end else begin
          done_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WB: begin
        rf_we_s = 1'b1;
        done_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q <= {WIDTH{1'b0}};
      b_q <= {WIDTH{1'b0}};
      c_q <= {WIDTH{1'b0}};
      flags_q <= 3'b000;
      done_q <= 1'b0;
      ready_q <= 1'b1;
      kind_q <= 2'd0;
      aluop_q <= 2'd0;
      shift_q <= 2'd0;
      rn_q <= {RW{1'b0}};
      rm_q <= {RW{1'b0}};
      rd_q <= {RW{1'b0}};
      asel_q <= 1'b0;
      bsel_q <= 1'b0;
      imm_q <= {IMM_W{1'b0}};
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      flags_q <= flags_d;
      done_q <= done_d;
      ready_q <= ready_d;
      kind_q <= kind_d;
      aluop_q <= aluop_d;
      shift_q <= shift_d;
      rn_q <= rn_d;
      rm_q <= rm_d;
      rd_q <= rd_d;
      asel_q <= asel_d;
      bsel_q <= bsel_d;
      imm_q <= imm_d;
    end
  end

  // Reset wins over any register-file write in the same cycle.
  regfile_param #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk   (clk),
    .we    (rf_we_s & ~reset),
    .waddr (rf_waddr_s),
    .wdata (rf_wdata_s),
    .raddr (rf_raddr_s),
    .rdata (rf_rdata_s)
  );

  assign op_ready = ready_q;
  assign result   = c_q;
  assign flags    = flags_q;
  assign done     = done_q;

endmodule

// File: tb/tb_datapath_seq.sv
module tb_datapath_seq;

  localparam int NR = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [1:0]  op_kind = 2'd0;
  logic [2:0]  op_rn = 3'd0, op_rm = 3'd0, op_rd = 3'd0;
  logic [1:0]  op_aluop = 2'd0, op_shift = 2'd0;
  logic        op_asel = 1'b0, op_bsel = 1'b0;
  logic [4:0]  op_imm = 5'd0;
  logic        ext_write = 1'b0;
  logic [2:0]  ext_num = 3'd0;
  logic [15:0] ext_data = 16'd0;
  logic [15:0] result;
  logic [2:0]  flags;
  logic        done;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int model_r [NR];
  int model_c = 0;
  logic [2:0] model_f = 3'b000;

  datapath_seq dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_kind(op_kind), .op_rn(op_rn), .op_rm(op_rm), .op_rd(op_rd),
    .op_aluop(op_aluop), .op_shift(op_shift), .op_asel(op_asel),
    .op_bsel(op_bsel), .op_imm(op_imm), .ext_write(ext_write),
    .ext_num(ext_num), .ext_data(ext_data), .result(result),
    .flags(flags), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sx(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Behavioural reference of one op on the architectural state.
  task automatic model_exec(input int kind, rn, rm, rd, aluop, shift, asel, bsel, imm);
    int a, bv, sb, b, r, s;
    logic v;
    if (kind == 0 || kind == 2) begin
      a = (asel != 0) ? 0 : model_r[rn];
      bv = model_r[rm];
      case (shift)
        0: sb = bv;
        1: sb = (bv * 2) % 65536;
        2: sb = bv / 2;
        default: sb = bv / 2 + ((bv >= 32768) ? 32768 : 0);
      endcase
      b = (bsel != 0) ? imm : sb;
      v = 1'b0;
      case (aluop)
        0: begin r = (a + b) % 65536; s = sx(a) + sx(b); v = (s > 32767) || (s < -32768); end
        1: begin r = (a - b + 65536) % 65536; s = sx(a) - sx(b); v = (s > 32767) || (s < -32768); end
        2: r = a & b;
        default: r = 65535 - b;
      endcase
      model_f = {r >= 32768, v, r == 0};
      if (kind == 0) begin
        model_c = r;
        model_r[rd] = r;
      end
    end else if (kind == 1) begin
      model_c = (imm >= 16) ? imm - 32 + 65536 : imm;
      model_r[rd] = model_c;
    end
  endtask

  task automatic ext_load(input int n, input int d);
    ext_write = 1'b1;
    ext_num = 3'(n);
    ext_data = 16'(d);
    tick();
    ext_write = 1'b0;
    model_r[n] = d;
  endtask

  task automatic start_op(input int kind, rn, rm, rd, aluop, shift, asel, bsel, imm,
                          input int ext_en, ext_n, ext_d);
    n_tests++;
    if (op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_op: got %b expected 1", op_ready);
    end
    op_valid = 1'b1;
    op_kind = 2'(kind); op_rn = 3'(rn); op_rm = 3'(rm); op_rd = 3'(rd);
    op_aluop = 2'(aluop); op_shift = 2'(shift);
    op_asel = (asel != 0); op_bsel = (bsel != 0); op_imm = 5'(imm);
    ext_write = (ext_en != 0); ext_num = 3'(ext_n); ext_data = 16'(ext_d);
    tick();
    acc_cyc = cyc;
    op_valid = 1'b0;
    ext_write = 1'b0;
    // Fields are don't-care after acceptance; scramble them.
    op_kind = 2'($urandom); op_rn = 3'($urandom); op_rm = 3'($urandom);
    op_rd = 3'($urandom); op_aluop = 2'($urandom); op_shift = 2'($urandom);
    op_asel = 1'($urandom); op_bsel = 1'($urandom); op_imm = 5'($urandom);
    if (ext_en != 0) model_r[ext_n] = ext_d;
  endtask

  task automatic wait_done(input int lat, input string name);
    int waited = 0;
    while (done !== 1'b1 && waited < 12) begin
      tick();
      waited++;
    end
    n_tests++;
    if (done !== 1'b1 || cyc - acc_cyc != lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles (done=%b) expected %0d", name, cyc - acc_cyc, done, lat);
    end
    n_tests++;
    if (result !== 16'(model_c)) begin
      n_fail++;
      $display("FAIL %s_result: got %h expected %h", name, result, 16'(model_c));
    end
    n_tests++;
    if (flags !== model_f) begin
      n_fail++;
      $display("FAIL %s_flags: got %b expected %b", name, flags, model_f);
    end
    n_tests++;
    if (op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_in_done: got %b expected 1", name, op_ready);
    end
  endtask

  function automatic int lat_of(input int kind);
    case (kind)
      0: return 4;
      1: return 1;
      2: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic run_op(input int kind, rn, rm, rd, aluop, shift, asel, bsel, imm,
                        input int ext_en, ext_n, ext_d, input string name);
    start_op(kind, rn, rm, rd, aluop, shift, asel, bsel, imm, ext_en, ext_n, ext_d);
    model_exec(kind, rn, rm, rd, aluop, shift, asel, bsel, imm);
    wait_done(lat_of(kind), name);
  endtask

  // Reads R[r] through the datapath (0 + R[r], written back unchanged).
  task automatic read_reg(input int r, input int expv, input string name);
    run_op(0, 0, r, r, 0, 0, 1, 0, 0, 0, 0, 0, name);
    n_tests++;
    if (result !== 16'(expv)) begin
      n_fail++;
      $display("FAIL %s_value: got %h expected %h", name, result, 16'(expv));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if (result !== 16'h0000 || flags !== 3'b000 || done !== 1'b0 || op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got result=%h flags=%b done=%b ready=%b expected 0000 000 0 1",
               result, flags, done, op_ready);
    end
    model_c = 0;
    model_f = 3'b000;
    for (int i = 0; i < NR; i++) ext_load(i, int'($urandom_range(0, 65535)));
  endtask

  task automatic test_add_cmp();
    ext_load(1, 7);
    ext_load(2, 3);
    run_op(0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, "add");
    n_tests++;
    if (result !== 16'd10 || flags !== 3'b000) begin
      n_fail++;
      $display("FAIL add_const: got %h/%b expected 000a/000", result, flags);
    end
    run_op(2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, "cmp");
    n_tests++;
    if (result !== 16'd10 || flags !== 3'b001) begin
      n_fail++;
      $display("FAIL cmp_const: got %h/%b expected 000a/001", result, flags);
    end
    read_reg(5, model_r[5], "cmp_no_write");
    read_reg(3, 10, "add_r3");
  endtask

  task automatic test_overflow();
    ext_load(1, 16'h7FFF);
    run_op(0, 1, 0, 6, 0, 0, 0, 1, 1, 0, 0, 0, "ovf");
    n_tests++;
    if (result !== 16'h8000 || flags !== 3'b110) begin
      n_fail++;
      $display("FAIL ovf_const: got %h/%b expected 8000/110", result, flags);
    end
  endtask

  task automatic test_shifts();
    logic [15:0] exp_s [3];
    exp_s[0] = 16'h0002; exp_s[1] = 16'h4000; exp_s[2] = 16'hC000;
    ext_load(2, 16'h8001);
    for (int s = 1; s <= 3; s++) begin
      run_op(0, 0, 2, 7, 0, s, 1, 0, 0, 0, 0, 0, "shift");
      n_tests++;
      if (result !== exp_s[s-1]) begin
        n_fail++;
        $display("FAIL shift_mode%0d: got %h expected %h", s, result, exp_s[s-1]);
      end
    end
  endtask

  task automatic test_mov_and_reset();
    int seen_done = 0;
    run_op(1, 0, 0, 4, 0, 0, 0, 0, 31, 0, 0, 0, "movi");
    n_tests++;
    if (result !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL movi_const: got %h expected ffff", result);
    end
    start_op(0, 1, 2, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    if (done === 1'b1) seen_done++;
    tick();                       // now in RDB
    if (done === 1'b1) seen_done++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_c = 0;
    model_f = 3'b000;
    n_tests++;
    if (op_ready !== 1'b1 || result !== 16'h0000 || flags !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_op: got ready=%b result=%h flags=%b expected 1 0000 000",
               op_ready, result, flags);
    end
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) seen_done++;
      tick();
    end
    n_tests++;
    if (seen_done != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d done samples expected 0", seen_done);
    end
    read_reg(5, model_r[5], "reset_rd_kept");
    read_reg(4, 16'hFFFF, "movi_r4");
  endtask

  task automatic test_reset_priority();
    int old5 = model_r[5];
    reset = 1'b1;
    op_valid = 1'b1; op_kind = 2'd0; op_rn = 3'd1; op_rm = 3'd2; op_rd = 3'd5;
    ext_write = 1'b1; ext_num = 3'd5; ext_data = 16'(~old5);
    tick();
    reset = 1'b0; op_valid = 1'b0; ext_write = 1'b0;
    model_c = 0;
    model_f = 3'b000;
    tick();
    n_tests++;
    if (op_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_priority_idle: got ready=%b done=%b expected 1 0", op_ready, done);
    end
    read_reg(5, old5, "reset_priority_reg");
  endtask

  task automatic test_ext_rules();
    int old5 = model_r[5];
    int v6 = int'($urandom_range(0, 65535));
    // ext write on the accept edge is visible to the new op's reads
    run_op(0, 6, 0, 7, 0, 0, 0, 0, 0, 1, 6, v6, "ext_same_edge");
    // ext writes while busy are dropped
    start_op(0, 1, 2, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    model_exec(0, 1, 2, 6, 1, 0, 0, 0, 0);
    ext_write = 1'b1; ext_num = 3'd5; ext_data = 16'(~old5);
    tick(); tick(); tick();
    ext_write = 1'b0;
    wait_done(4, "ext_busy_op");
    read_reg(5, old5, "ext_busy_ignored");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      int k = int'($urandom_range(0, 3));
      int e = ($urandom_range(0, 3) == 0) ? 1 : 0;
      run_op(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
             e, int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)), "random");
      if ($urandom_range(0, 2) == 0) tick();
    end
    for (int r = 0; r < NR; r++) read_reg(r, model_r[r], "final_reg");
  endtask

  initial begin
    test_reset();
    test_add_cmp();
    test_overflow();
    test_shifts();
    test_mov_and_reset();
    test_reset_priority();
    test_ext_rules();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised, self-sequenced successor to the lab datapath: register file, A/B operand registers, shifter, ALU, result register C and status flags.
- Generalised in data width and register count, and adds a multi-flag status register (Z, N, V).
- An internal FSM sequences each operation from a valid/ready op request, so the controller issues whole operations instead of per-cycle load enables.
- Sits between the instruction decoder/controller and the memory/host interface.

Parameters:
- WIDTH, 16, datapath and register width (>= 8).
- NREGS, 8, register-file depth (power of 2, >= 2).
- IMM_W, 5, immediate field width (< WIDTH).
- RW, $clog2(NREGS), register index width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  operation request.
- op_ready  out  1  high when the block can accept an op.
- op_kind  in  2  0=ALU, 1=MOV_IMM, 2=CMP (flags only), 3=reserved (treated as NOP).
- op_rn  in  RW  A-operand register.
- op_rm  in  RW  B-operand register.
- op_rd  in  RW  destination register.
- op_aluop  in  2  0=ADD, 1=SUB, 2=AND, 3=NOT B.
- op_shift  in  2  0=none, 1=LSL1, 2=LSR1 with MSB 0, 3=ASR1.
- op_asel  in  1  1: A operand forced to 0.
- op_bsel  in  1  1: B operand = zero-extended op_imm.
- op_imm  in  IMM_W  immediate.
- ext_write  in  1  host register load.
- ext_num  in  RW  host target register.
- ext_data  in  WIDTH  host load data.
- result  out  WIDTH  C register.
- flags  out  3  {N, V, Z}, registered.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: FSM to IDLE; result=0, flags=0, done=0, A/B=0, any in-flight op discarded with no register write. Register-file contents are not cleared.
- op_ready = (state==IDLE). An op is accepted on a rising edge where op_valid && op_ready; op fields are captured at that edge and are don't-care afterwards.
- FSM path for ALU/CMP: IDLE -> RDA -> RDB -> EXEC -> (WB if ALU) -> IDLE.
  - RDA: A <= R[rn].
  - RDB: B <= R[rm].
  - EXEC: ALU computes; flags always load. For ALU ops, C loads the ALU result. For CMP, C holds.
  - WB: R[rd] <= C.
- FSM path for MOV_IMM: IDLE -> WB. C <= sign-extended op_imm, R[rd] <= that value; flags unchanged.
- Reserved op_kind (3): IDLE -> IDLE. Done pulses on the edge after acceptance; no state change.
- Datapath: operand A = asel ? 0 : A. Operand B = bsel ? zext(imm) : shift(B).
- Arithmetic: all arithmetic is mod 2^WIDTH.
- Flags:
  - Z = (ALU out == 0).
  - N = ALU out[WIDTH-1].
  - V = signed overflow for ADD/SUB; V = 0 for AND/NOT.
- done timing:
  - done is a registered pulse, high for exactly the cycle after the final state of an op.
  - ALU op accepted at edge T: done high in cycle T+4 to T+5, and the new R[rd] is readable from T+4.
  - CMP op: done high in cycle T+3 to T+4.
  - MOV_IMM op: done high in cycle T+1 to T+2.
- Back-to-back ops: op_ready rises in the cycle done is high, so a new op may be accepted at the edge ending the done cycle. There is no overlap between ops.
- ext_write:
  - Honoured only when state==IDLE; ignored otherwise, with no queueing.
  - If ext_write and an op are accepted at the same edge, the ext write lands at that edge, and RDA/RDB of the new op read the updated value.
- Reset asserted in any state has priority over all other events, including a same-cycle handshake or ext_write.

Decomposition:
- Shared package datapath_pkg: ALUOP_* and SHIFT_* codes, OPK_* codes, FSM state enum, flag bit indices.
- One natural sub-module: regfile_param (WIDTH, NREGS): 1 write port, 1 combinational read port.
- Shifter and ALU stay inline as combinational functions.

Test Plan:
- Reset then idle: result=0, flags=3'b000, done=0, op_ready=1.
- ext_write R1=7, R2=3; ALU ADD rn=1 rm=2 rd=3 accepted at T -> done at T+4, result=10, flags Z=0 N=0 V=0, R3=10.
- CMP SUB rn=1 rm=1 -> done at T+3, flags Z=1; result unchanged at 10; no register write.
- WIDTH=16: R1=16'h7FFF, ADD rm with bsel=1 imm=1 -> result=16'h8000, N=1, V=1, Z=0.
- Shift modes on B=16'h8001: LSL1 -> 16'h0002; LSR1 -> 16'h4000; ASR1 -> 16'hC000 (asel=1, ADD).
- MOV_IMM rd=4 imm=5'b11111 -> R4=16'hFFFF, done at T+1. Then issue an ALU op and assert reset during RDB -> no done pulse, rd unchanged, op_ready=1 the cycle after reset.
